// File: rtl/pipeline_elastic.sv
// pipeline_elastic: a valid/ready pipeline made of PIPELINE_STAGES cascaded register slices.
// MODE 0 uses forward slices. Each forward slice registers data and valid, holds one entry, and
// computes its ready combinationally. MODE 1 uses full slices. Each full slice has a main register
// and a skid register, holds two entries, and registers its ready. The block supports a
// synchronous flush and reports a registered occupancy count.
module pipeline_elastic #(
  parameter int  DATA_WIDTH      = 32,
  parameter int  PIPELINE_STAGES = 4,
  parameter int  MODE            = 1,
  localparam int OCC_W           = $clog2(PIPELINE_STAGES * (MODE + 1) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] u_data,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  input  logic                  flush,
  output logic [OCC_W-1:0]      occupancy
);

  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $fatal(1, "pipeline_elastic: MODE must be 0 or 1");
  end
  if (PIPELINE_STAGES < 1) begin : g_bad_stages
    $fatal(1, "pipeline_elastic: PIPELINE_STAGES must be at least 1");
  end

  // No handshake may complete while the block is in reset or being flushed.
  logic run;
  assign run = rst_n && !flush;

  for (genvar k = 0; k < PIPELINE_STAGES; k++) begin : g_slice
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  rdy;       // ready this slice offers upstream
    logic                  nxt_rdy;   // ready offered by the consumer of this slice
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    if (k == 0) begin : g_head
      assign in_valid = u_valid && run;
      assign in_data  = u_data;
    end else begin : g_link
      assign in_valid = g_slice[k-1].out_valid;
      assign in_data  = g_slice[k-1].out_data;
    end

    if (k == PIPELINE_STAGES - 1) begin : g_tail
      assign nxt_rdy = d_ready && run;
    end else begin : g_next
      assign nxt_rdy = g_slice[k+1].rdy;
    end

    if (MODE == 0) begin : g_fwd
      logic                  valid_q, valid_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;

      assign rdy       = !valid_q || nxt_rdy;
      assign out_valid = valid_q;
      assign out_data  = data_q;

      // Next state: load whatever is offered whenever this slice can move.
      always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        if (rdy) begin
          valid_d = in_valid;
          if (in_valid) data_d = in_data;
        end
      end

      // Slice register; data is left alone on flush and only the valid is dropped.
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
          valid_q <= 1'b0;
          // NOTE: payload flops are reset too, because d_data must read zero out of reset.
          data_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
    end else begin : g_full
      // Slice state is {main_valid_q, skid_valid_q}: EMPTY 00, BUSY 10, FULL 11.
      logic                  main_valid_q, main_valid_d;
      logic                  skid_valid_q, skid_valid_d;
      logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
      logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
      logic                  in_fire;
      logic                  out_fire;

      assign rdy       = !skid_valid_q;
      assign out_valid = main_valid_q;
      assign out_data  = main_data_q;
      assign in_fire   = in_valid && !skid_valid_q;
      assign out_fire  = main_valid_q && nxt_rdy;

      // Next state: main refills from skid before taking new input; skid catches input on a stall.
      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || out_fire) begin
          if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else begin
            main_valid_d = in_fire;
            if (in_fire) main_data_d = in_data;
          end
        end else if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end

      // Main and skid registers; a flush empties both without touching the payloads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          main_data_q  <= '0;
          skid_data_q  <= '0;
        end else if (flush) begin
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
        end else begin
          main_valid_q <= main_valid_d;
          skid_valid_q <= skid_valid_d;
          main_data_q  <= main_data_d;
          skid_data_q  <= skid_data_d;
        end
      end
    end
  end

  assign u_ready = g_slice[0].rdy && run;
  assign d_valid = g_slice[PIPELINE_STAGES-1].out_valid && run;
  assign d_data  = g_slice[PIPELINE_STAGES-1].out_data;

  logic             u_fire;
  logic             d_fire;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign u_fire    = u_valid && u_ready;
  assign d_fire    = d_valid && d_ready;
  assign occupancy = occ_q;

  // Occupancy tracks port handshakes; it cannot exceed capacity because u_ready drops when full.
  always_comb begin
    occ_d = occ_q + OCC_W'(u_fire) - OCC_W'(d_fire);
  end

  // Occupancy register, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) occ_q <= '0;
    else                 occ_q <= occ_d;
  end

endmodule

// File: tb/tb_pipeline_elastic.sv
// Testbench for pipeline_elastic. It drives one MODE 0 and one MODE 1 instance with the same
// stimulus and observes the instance selected by mode_sel. A queue scoreboard records accepted
// items and checks that they come out in order.
module tb_pipeline_elastic;
  localparam int DW = 32;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n, u_valid, d_ready, flush;
  logic [DW-1:0] u_data;
  logic          u_ready0, d_valid0, u_ready1, d_valid1;
  logic [DW-1:0] d_data0, d_data1;
  logic [2:0]    occ0;
  logic [3:0]    occ1;

  pipeline_elastic #(.DATA_WIDTH(DW), .PIPELINE_STAGES(ST), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .u_data(u_data), .u_valid(u_valid), .u_ready(u_ready0),
    .d_data(d_data0), .d_valid(d_valid0), .d_ready(d_ready), .flush(flush), .occupancy(occ0)
  );

  pipeline_elastic #(.DATA_WIDTH(DW), .PIPELINE_STAGES(ST), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .u_data(u_data), .u_valid(u_valid), .u_ready(u_ready1),
    .d_data(d_data1), .d_valid(d_valid1), .d_ready(d_ready), .flush(flush), .occupancy(occ1)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            delivered = 0;
  bit            mode_sel = 1'b0;
  bit            hold_en = 1'b0;
  logic          su_ready, sd_valid;
  logic [DW-1:0] sd_data;
  logic [3:0]    socc;
  logic          prev_dv = 1'b0, prev_dr = 1'b0;
  logic [DW-1:0] prev_dd = '0;
  logic [DW-1:0] exp_q[$];

  // One clock cycle: inputs are already set at the preceding negedge. The task samples the
  // outputs just after that, updates the scoreboard, and then returns at the next negedge.
  task automatic tick();
    logic [DW-1:0] exp;
    #1;
    su_ready = mode_sel ? u_ready1 : u_ready0;
    sd_valid = mode_sel ? d_valid1 : d_valid0;
    sd_data  = mode_sel ? d_data1 : d_data0;
    socc     = mode_sel ? occ1 : {1'b0, occ0};
    if (hold_en && prev_dv && !prev_dr) begin
      n_tests++;
      if (sd_valid !== 1'b1 || sd_data !== prev_dd) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%0b data=%0d, need valid=1 data=%0d",
                 sd_valid, sd_data, prev_dd);
      end
    end
    if (u_valid && su_ready) exp_q.push_back(u_data);
    if (sd_valid && d_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: got unexpected item %0d, need nothing", sd_data);
      end else begin
        exp = exp_q.pop_front();
        if (sd_data !== exp) begin
          n_fail++;
          $display("FAIL scoreboard: got %0d, need %0d", sd_data, exp);
        end
      end
      delivered++;
    end
    if (!rst_n || flush) exp_q.delete();
    prev_dv = sd_valid;
    prev_dr = d_ready;
    prev_dd = sd_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    hold_en = 1'b0;
    rst_n = 1'b0; u_valid = 1'b0; u_data = '0; d_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    delivered = 0;
    prev_dv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; u_valid = 1'b1; u_data = 7; d_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({u_ready0, u_ready1, d_valid0, d_valid1} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_handshake: got u_ready=%0b%0b d_valid=%0b%0b, need 00 00",
                 u_ready0, u_ready1, d_valid0, d_valid1);
      end
      n_tests++;
      if (d_data0 !== 0 || d_data1 !== 0) begin
        n_fail++;
        $display("FAIL reset_d_data: got %0d/%0d, need 0/0", d_data0, d_data1);
      end
      n_tests++;
      if (occ0 !== 0 || occ1 !== 0) begin
        n_fail++;
        $display("FAIL reset_occupancy: got %0d/%0d, need 0/0", occ0, occ1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_acc, first_dv, last_dv, sent, now;
    mode_sel = 1'b1;
    do_reset();
    hold_en = 1'b1;
    first_acc = -1; first_dv = -1; last_dv = -1; sent = 0;
    d_ready = 1'b1;
    for (int c = 0; c < 200 && delivered < 100; c++) begin
      u_valid = (sent < 100);
      u_data  = sent;
      now = cyc;
      tick();
      if (sd_valid) begin
        if (first_dv < 0) first_dv = now;
        last_dv = now;
      end
      if (u_valid && su_ready) begin
        if (first_acc < 0) first_acc = now;
        if (now - first_acc >= ST) begin
          n_tests++;
          if (socc !== 4'd4) begin
            n_fail++;
            $display("FAIL b2b_occupancy: got %0d, need 4", socc);
          end
        end
        sent++;
      end
    end
    u_valid = 1'b0;
    n_tests++;
    if (delivered != 100) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d items, need 100", delivered);
    end
    n_tests++;
    if (first_dv - first_acc != ST) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d cycles, need %0d", first_dv - first_acc, ST);
    end
    n_tests++;
    if (last_dv - first_dv != 99) begin
      n_fail++;
      $display("FAIL b2b_throughput: got span %0d cycles, need 99", last_dv - first_dv);
    end
  endtask

  task automatic test_full_skid();
    int sent;
    bit back;
    mode_sel = 1'b1;
    do_reset();
    hold_en = 1'b1;
    sent = 0;
    d_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      u_valid = 1'b1; u_data = sent;
      tick();
      if (su_ready) sent++;
    end
    n_tests++;
    if (sent != 8) begin
      n_fail++;
      $display("FAIL skid_capacity: got %0d accepted, need 8", sent);
    end
    n_tests++;
    if (su_ready !== 1'b0 || socc !== 4'd8) begin
      n_fail++;
      $display("FAIL skid_full: got u_ready=%0b occ=%0d, need 0 and 8", su_ready, socc);
    end
    n_tests++;
    if (sd_valid !== 1'b1 || sd_data !== 0) begin
      n_fail++;
      $display("FAIL skid_head: got valid=%0b data=%0d, need 1 and 0", sd_valid, sd_data);
    end
    d_ready = 1'b1; u_data = sent;
    tick();
    n_tests++;
    if (su_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL skid_ready_registered: got u_ready=%0b, need 0", su_ready);
    end
    back = 1'b0;
    for (int c = 0; c < 10 && !back; c++) begin
      u_data = sent;
      tick();
      if (su_ready) begin back = 1'b1; sent++; end
    end
    n_tests++;
    if (!back) begin
      n_fail++;
      $display("FAIL skid_ready_return: got u_ready=0 for 10 cycles, need 1");
    end
    for (int c = 0; c < 100 && sent < 20; c++) begin
      u_data = sent;
      tick();
      if (su_ready) sent++;
    end
    u_valid = 1'b0;
    for (int c = 0; c < 50 && delivered < 20; c++) tick();
    tick();
    n_tests++;
    if (delivered != 20 || socc !== 4'd0) begin
      n_fail++;
      $display("FAIL skid_drain: got %0d items occ=%0d, need 20 and 0", delivered, socc);
    end
  endtask

  task automatic test_forward_full();
    int sent;
    mode_sel = 1'b0;
    do_reset();
    hold_en = 1'b1;
    sent = 0;
    d_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      u_valid = 1'b1; u_data = 100 + sent;
      tick();
      if (su_ready) sent++;
    end
    n_tests++;
    if (sent != 4 || socc !== 4'd4 || su_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_full: got acc=%0d occ=%0d u_ready=%0b, need 4 4 0", sent, socc, su_ready);
    end
    d_ready = 1'b1; u_data = 100 + sent;
    tick();
    n_tests++;
    if (su_ready !== 1'b1 || sd_valid !== 1'b1 || socc !== 4'd4) begin
      n_fail++;
      $display("FAIL fwd_pass_through: got u_ready=%0b d_valid=%0b occ=%0d, need 1 1 4",
               su_ready, sd_valid, socc);
    end
    if (su_ready) sent++;
    u_data = 100 + sent;
    tick();
    if (su_ready) sent++;
    n_tests++;
    if (socc !== 4'd4) begin
      n_fail++;
      $display("FAIL fwd_occ_steady: got %0d, need 4", socc);
    end
    u_valid = 1'b0;
    for (int c = 0; c < 20 && delivered < sent; c++) tick();
    n_tests++;
    if (delivered != sent || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fwd_drain: got %0d items, need %0d", delivered, sent);
    end
  endtask

  task automatic test_random();
    int sent, bubble, stall;
    for (int m = 0; m < 2; m++) begin
      mode_sel = m[0];
      do_reset();
      hold_en = 1'b1;
      sent = 0; stall = 0;
      bubble = int'($urandom_range(0, 3));
      for (int c = 0; c < 3000 && delivered < 100; c++) begin
        if (sent < 100 && bubble == 0) begin
          u_valid = 1'b1; u_data = sent;
        end else begin
          u_valid = 1'b0; u_data = $urandom;
          if (bubble > 0) bubble--;
        end
        if (stall > 0) begin
          d_ready = 1'b0; stall--;
        end else begin
          d_ready = 1'b1; stall = int'($urandom_range(0, 3));
        end
        tick();
        if (u_valid && su_ready) begin
          sent++;
          bubble = int'($urandom_range(0, 3));
        end
      end
      u_valid = 1'b0;
      n_tests++;
      if (delivered != 100 || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL random_mode%0d: got %0d items (%0d pending), need 100 (0)",
                 m, delivered, exp_q.size());
      end
    end
  endtask

  task automatic test_flush();
    int sent, acc, dv;
    bit seen;
    for (int pass = 0; pass < 2; pass++) begin
      mode_sel = 1'b1;
      do_reset();
      sent = 0;
      d_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
        u_valid = 1'b1; u_data = sent;
        tick();
        if (su_ready) sent++;
      end
      u_data = sent;
      if (pass == 0) flush = 1'b1;
      else           rst_n = 1'b0;
      tick();
      n_tests++;
      if (su_ready !== 1'b0 || sd_valid !== 1'b0 || socc !== 4'd5) begin
        n_fail++;
        $display("FAIL discard%0d_cycle: got u_ready=%0b d_valid=%0b occ=%0d, need 0 0 5",
                 pass, su_ready, sd_valid, socc);
      end
      flush = 1'b0; rst_n = 1'b1; u_valid = 1'b0;
      tick();
      n_tests++;
      if (socc !== 4'd0 || sd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL discard%0d_empty: got occ=%0d d_valid=%0b, need 0 0", pass, socc, sd_valid);
      end
      d_ready = 1'b1; u_valid = 1'b1; u_data = 42;
      acc = cyc;
      tick();
      n_tests++;
      if (su_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL discard%0d_accept: got u_ready=%0b, need 1", pass, su_ready);
      end
      u_valid = 1'b0;
      seen = 1'b0; dv = -1;
      for (int c = 0; c < 10 && !seen; c++) begin
        dv = cyc;
        tick();
        if (sd_valid) seen = 1'b1;
      end
      n_tests++;
      if (!seen || dv - acc != ST || sd_data !== 42) begin
        n_fail++;
        $display("FAIL discard%0d_latency: got seen=%0b lat=%0d data=%0d, need 1 %0d 42",
                 pass, seen, dv - acc, sd_data, ST);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; u_valid = 1'b0; u_data = '0; d_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_full_skid();
    test_forward_full();
    test_random();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cycle %0d, need bench completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
